// File: rtl/alu_writeback_stage.sv
// Writeback stage: 2-entry in-order queue between the ALU and the register-file write port.
// Optional forwarding outputs (fwd_valid/fwd_addr/fwd_data) are built when ALU_WB_FWD_EN is defined.
module alu_writeback_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic                  in_z,
  input  logic                  in_n,
  input  logic                  in_c,
  input  logic                  in_v,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic                  in_wr_en,
  input  logic                  in_flag_en,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic                  rf_ready,
  output logic [3:0]            flags,
  output logic                  busy
`ifdef ALU_WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    return {n, z, c, v};
  endfunction

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [3:0] flags_q, flags_d;

  // Queue payload; validity is tracked by count_q, so these need no reset.
  logic [DATA_W-1:0]     res_q     [2];
  logic [3:0]            eflags_q  [2];
  logic [REG_ADDR_W-1:0] dest_q    [2];
  logic                  wr_en_q   [2];
  logic                  flag_en_q [2];

  logic                  not_empty;
  logic                  not_full;
  logic                  push;
  logic                  retire;
  logic [DATA_W-1:0]     head_res;
  logic [3:0]            head_flags;
  logic [REG_ADDR_W-1:0] head_dest;
  logic                  head_wr_en;
  logic                  head_flag_en;

  always_comb begin
    not_empty    = (count_q != 2'd0);
    not_full     = (count_q != 2'd2);
    head_res     = res_q[rd_ptr_q];
    head_flags   = eflags_q[rd_ptr_q];
    head_dest    = dest_q[rd_ptr_q];
    head_wr_en   = wr_en_q[rd_ptr_q];
    head_flag_en = flag_en_q[rd_ptr_q];
    push         = in_valid && not_full;
    // Entries without a register write never wait on rf_ready.
    retire       = not_empty && (!head_wr_en || rf_ready);
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ retire;
    flags_d  = flags_q;
    case ({push, retire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (retire && head_flag_en) begin
      flags_d = head_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      flags_q  <= 4'b0000;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      flags_q  <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      res_q[wr_ptr_q]     <= in_result;
      eflags_q[wr_ptr_q]  <= pack_flags(in_n, in_z, in_c, in_v);
      dest_q[wr_ptr_q]    <= in_dest;
      wr_en_q[wr_ptr_q]   <= in_wr_en;
      flag_en_q[wr_ptr_q] <= in_flag_en;
    end
  end

  // Write port is a pure function of the head and count, so it holds while stalled.
  always_comb begin
    in_ready = not_full;
    busy     = not_empty;
    flags    = flags_q;
    rf_we    = not_empty && head_wr_en;
    rf_waddr = not_empty ? head_dest : '0;
    rf_wdata = not_empty ? head_res  : '0;
  end

`ifdef ALU_WB_FWD_EN
  logic                  fwd_valid_q;
  logic [REG_ADDR_W-1:0] fwd_addr_q;
  logic [DATA_W-1:0]     fwd_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
    end else if (rf_we && rf_ready) begin
      fwd_valid_q <= 1'b1;
      fwd_addr_q  <= rf_waddr;
      fwd_data_q  <= rf_wdata;
    end
  end

  always_comb begin
    fwd_valid = fwd_valid_q;
    fwd_addr  = fwd_addr_q;
    fwd_data  = fwd_data_q;
  end
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Scoreboard bench for alu_writeback_stage: directed scenarios followed by randomized traffic.
module tb_alu_writeback_stage;

  typedef struct packed {
    logic [15:0] res;
    logic        z, n, c, v;
    logic [2:0]  dest;
    logic        wr_en, flag_en;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_result = '0;
  logic        in_z = 1'b0, in_n = 1'b0, in_c = 1'b0, in_v = 1'b0;
  logic [2:0]  in_dest = '0;
  logic        in_wr_en = 1'b0, in_flag_en = 1'b0;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_ready = 1'b0;
  logic [3:0]  flags;
  logic        busy;
`ifdef ALU_WB_FWD_EN
  logic        fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: accepted entries in order; the first mcount are inside the DUT.
  ent_t       q[$];
  int         mcount = 0;
  logic [3:0] exp_flags = 4'b0000;
  logic       exp_fv = 1'b0;
  logic [2:0] exp_fa = '0;
  logic [15:0] exp_fd = '0;
  bit         rnd_on = 1'b0;

  alu_writeback_stage #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_z(in_z), .in_n(in_n), .in_c(in_c), .in_v(in_v),
    .in_dest(in_dest), .in_wr_en(in_wr_en), .in_flag_en(in_flag_en),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .flags(flags), .busy(busy)
`ifdef ALU_WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t mk(input logic [15:0] res, input logic [2:0] dest,
                              input logic wr_en, input logic flag_en,
                              input logic n, input logic z, input logic c, input logic v);
    ent_t e;
    e.res = res; e.dest = dest; e.wr_en = wr_en; e.flag_en = flag_en;
    e.n = n; e.z = z; e.c = c; e.v = v;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input ent_t e);
    bit acc;
    int n;
    in_valid = 1'b1; in_result = e.res; in_dest = e.dest;
    in_wr_en = e.wr_en; in_flag_en = e.flag_en;
    in_n = e.n; in_z = e.z; in_c = e.c; in_v = e.v;
    q.push_back(e);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      chk("send_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares DUT outputs against the model each cycle, then advances the model.
  always @(negedge clk) begin
    ent_t h;
    logic ret, psh;
    h = '0;
    if (!rst_n) begin
      q.delete();
      mcount = 0;
      exp_flags = 4'b0000;
      exp_fv = 1'b0; exp_fa = '0; exp_fd = '0;
    end else begin
      if (mcount > 0) h = q[0];
      chk("busy", busy, mcount != 0);
      chk("in_ready", in_ready, mcount < 2);
      chk("rf_we", rf_we, (mcount > 0) && h.wr_en);
      if (mcount == 0) begin
        chk("rf_waddr_idle", rf_waddr, 0);
        chk("rf_wdata_idle", rf_wdata, 0);
      end else if (h.wr_en) begin
        chk("rf_waddr", rf_waddr, h.dest);
        chk("rf_wdata", rf_wdata, h.res);
      end
      chk("flags", flags, exp_flags);
`ifdef ALU_WB_FWD_EN
      chk("fwd_valid", fwd_valid, exp_fv);
      chk("fwd_addr", fwd_addr, exp_fa);
      chk("fwd_data", fwd_data, exp_fd);
`endif
      ret = (mcount > 0) && (!h.wr_en || rf_ready);
      psh = in_valid && (mcount < 2);
      if (psh && q.size() <= mcount) chk("model_queue", q.size(), mcount + 1);
      if (ret) begin
        if (h.flag_en) exp_flags = {h.n, h.z, h.c, h.v};
        if (h.wr_en) begin
          exp_fv = 1'b1; exp_fa = h.dest; exp_fd = h.res;
        end
        void'(q.pop_front());
        mcount--;
      end
      if (psh) mcount++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(2);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_flags", flags, 0);
    rst_n = 1'b1;
    step(1);

    // Single push: write appears next cycle, flags the cycle after retire.
    rf_ready = 1'b1;
    send(mk(16'h8000, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    chk("t1_rf_we", rf_we, 1);
    chk("t1_rf_waddr", rf_waddr, 3);
    chk("t1_rf_wdata", rf_wdata, 16'h8000);
    step(1);
    chk("t1_flags", flags, 4'b1000);
    chk("t1_busy", busy, 0);

    // Stall: queue fills to two, third push waits, writes drain in order.
    rf_ready = 1'b0;
    send(mk(16'h1111, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    send(mk(16'h2222, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    fork
      send(mk(16'h3333, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      begin
        chk("t2_in_ready_full", in_ready, 0);
        chk("t2_hold_data", rf_wdata, 16'h1111);
        step(1);
        chk("t2_hold_data2", rf_wdata, 16'h1111);
        chk("t2_hold_we", rf_we, 1);
        rf_ready = 1'b1;
      end
    join
    step(4);
    chk("t2_drained", busy, 0);

    // Flag-only entry: no register write, flags update two cycles after push.
    rf_ready = 1'b0;
    send(mk(16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    chk("t3_no_we", rf_we, 0);
    step(1);
    chk("t3_flags", flags, 4'b0100);
    chk("t3_busy", busy, 0);

    // Flag-enabled then flag-disabled entry: the second entry's flags never commit.
    rf_ready = 1'b1;
    send(mk(16'h00c0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    send(mk(16'h000f, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    step(3);
    chk("t4_flags", flags, 4'b0010);

    // Asynchronous reset with a full, stalled queue.
    rf_ready = 1'b0;
    send(mk(16'haaaa, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    send(mk(16'h5555, 3'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    chk("t5_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rf_we", rf_we, 0);
    chk("t5_rf_waddr", rf_waddr, 0);
    chk("t5_rf_wdata", rf_wdata, 0);
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 1);
    chk("t5_flags", flags, 0);
    step(1);
    rst_n = 1'b1;
    rf_ready = 1'b1;
    step(3);
    chk("t5_no_we_after", rf_we, 0);
    chk("t5_idle_after", busy, 0);

`ifdef ALU_WB_FWD_EN
    chk("t6_fwd_reset", fwd_valid, 0);
    send(mk(16'h1234, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step(1);
    chk("t6_fwd_valid", fwd_valid, 1);
    chk("t6_fwd_addr", fwd_addr, 5);
    chk("t6_fwd_data", fwd_data, 16'h1234);
    send(mk(16'hffff, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    step(2);
    chk("t6_fwd_hold_addr", fwd_addr, 5);
    chk("t6_fwd_hold_data", fwd_data, 16'h1234);
`endif

    // Randomized traffic with random back-pressure.
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          rf_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1);
      end else begin
        send(mk(16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)));
      end
    end
    rnd_on = 1'b0;
    step(2);
    #1 rf_ready = 1'b1;
    for (int i = 0; i < 20 && mcount > 0; i++) step(1);
    chk("final_drained", mcount, 0);
    step(1);
    chk("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
